vga_timing_gen: RTL

//  Generates 640x480@60 VGA raster timing: h/v counters, xpix/ypix scan coordinates and hsync/vsync.

---
 rtl/pong_vga_pkg.sv | 22 ++
 rtl/vga_axis_counter.sv | 33 +++
 rtl/vga_timing_gen.sv | 70 +++++++
 3 files changed

// File: rtl/pong_vga_pkg.sv
// pong_vga_pkg: shared 640x480@60 VGA timing constants and phase decoding
//   COORD_W         coordinate width shared with the display controller
//   H_* / V_*       default porch/sync/active lengths, H_TOTAL/V_TOTAL derived
//   phase_t         raster phase of one axis
//   decode_phase()  comparator decode of a counter value into its phase
package pong_vga_pkg;
  localparam int COORD_W = 10;
  localparam int H_ACTIVE = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_ACTIVE = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  typedef enum logic [1:0] {PH_ACTIVE, PH_FP, PH_SYNC, PH_BP} phase_t;
  function automatic phase_t decode_phase(input int c, input int act, input int fp, input int sync);
    return (c < act) ? PH_ACTIVE : (c < act + fp) ? PH_FP : (c < act + fp + sync) ? PH_SYNC : PH_BP;
  endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis counter with phase decode
//   clk, rst_n   clock, async active-low reset
//   inc          advance the count by one
//   wrap         inc while at the last count (carry into the next axis)
//   count        current position, 0..ACTIVE+FP+SYNC+BP-1
//   in_active    count inside the visible region
//   in_sync      count inside the sync pulse region
module vga_axis_counter
  import pong_vga_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE,
  parameter int FP = H_FP,
  parameter int SYNC = H_SYNC,
  parameter int BP = H_BP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  output logic               wrap,
  output logic [COORD_W-1:0] count,
  output logic               in_active,
  output logic               in_sync
);
  localparam logic [COORD_W-1:0] LAST = COORD_W'(ACTIVE + FP + SYNC + BP - 1);
  phase_t phase;
  assign wrap = inc && count == LAST;
  assign phase = decode_phase(int'(count), ACTIVE, FP, SYNC);
  assign in_active = phase == PH_ACTIVE;
  assign in_sync = phase == PH_SYNC;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (inc) count <= (count == LAST) ? '0 : count + COORD_W'(1);
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA raster timing with a registered, sync-aligned pixel output
//   clk, rst_n   clock, async active-low reset
//   pix_ce       pixel clock enable; everything advances only when 1
//   pixval       pixel-on from the display controller (combinational from xpix/ypix)
//   test_mode    only with VGA_TESTPAT_EN: 1 selects a 32-px checkerboard instead of pixval
//   xpix, ypix   current horizontal/vertical counters
//   video_on     current position is visible (undelayed)
//   hsync, vsync sync outputs, one pixel behind xpix/ypix
//   pix_out      registered pixel, aligned with hsync/vsync
//   frame_tick   one-clk pulse when the raster enters (0, V_ACTIVE)
module vga_timing_gen
  import pong_vga_pkg::*;
#(
  parameter int H_ACTIVE = pong_vga_pkg::H_ACTIVE,
  parameter int H_FP = pong_vga_pkg::H_FP,
  parameter int H_SYNC = pong_vga_pkg::H_SYNC,
  parameter int H_BP = pong_vga_pkg::H_BP,
  parameter int V_ACTIVE = pong_vga_pkg::V_ACTIVE,
  parameter int V_FP = pong_vga_pkg::V_FP,
  parameter int V_SYNC = pong_vga_pkg::V_SYNC,
  parameter int V_BP = pong_vga_pkg::V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_ce,
  input  logic               pixval,
`ifdef VGA_TESTPAT_EN
  input  logic               test_mode,
`endif
  output logic [COORD_W-1:0] xpix,
  output logic [COORD_W-1:0] ypix,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output logic               pix_out,
  output logic               frame_tick
);
  localparam logic [COORD_W-1:0] V_LAST_ACTIVE = COORD_W'(V_ACTIVE - 1);
  logic h_wrap, v_wrap_unused, h_act, v_act, h_in_sync, v_in_sync, pix_src;
  vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
    .clk(clk), .rst_n(rst_n), .inc(pix_ce), .wrap(h_wrap),
    .count(xpix), .in_active(h_act), .in_sync(h_in_sync)
  );
  vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
    .clk(clk), .rst_n(rst_n), .inc(h_wrap), .wrap(v_wrap_unused),
    .count(ypix), .in_active(v_act), .in_sync(v_in_sync)
  );
  assign video_on = h_act && v_act;
`ifdef VGA_TESTPAT_EN
  assign pix_src = test_mode ? xpix[5] ^ ypix[5] : pixval;
`else
  assign pix_src = pixval;
`endif
  // h_wrap already implies pix_ce, so the tick fires on the edge that loads (0, V_ACTIVE)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
      pix_out <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= h_wrap && ypix == V_LAST_ACTIVE;
      if (pix_ce) begin
        hsync <= h_in_sync ? SYNC_POL : ~SYNC_POL;
        vsync <= v_in_sync ? SYNC_POL : ~SYNC_POL;
        pix_out <= pix_src & video_on;
      end
    end
endmodule
